// File: rtl/button_event_decoder_if.sv
// Event handshake bundle between the button decoder and its consumer.
// master: evt_valid/evt_code out, evt_ready in; slave: the mirror image.
interface button_event_decoder_if;
  logic       evt_valid;
  logic [1:0] evt_code;
  logic       evt_ready;

  modport master (
    output evt_valid,
    output evt_code,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_code,
    output evt_ready
  );
endinterface

// File: rtl/button_event_decoder.sv
// Classifies debounced presses into SHORT/LONG/DOUBLE events on a valid/ready port.
// Ports: clk, reset (sync, high), btn, evt (master), overflow (sticky), busy.
// Optional macro BUTTON_DECODER_REPEAT_EN adds periodic REPEAT (00) events in HELD.
module button_event_decoder #(
  parameter int unsigned TICK_DIV   = 50000,
  parameter int unsigned LONG_TICKS = 500,
  parameter int unsigned GAP_TICKS  = 250,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          btn,
  button_event_decoder_if.master        evt,
  output logic                          overflow,
  output logic                          busy
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_PRESSED  = 3'd1;
  localparam logic [2:0] S_HELD     = 3'd2;
  localparam logic [2:0] S_WAIT_GAP = 3'd3;
  localparam logic [2:0] S_SECOND   = 3'd4;

  localparam logic [1:0] C_SHORT  = 2'b01;
  localparam logic [1:0] C_LONG   = 2'b10;
  localparam logic [1:0] C_DOUBLE = 2'b11;

  localparam logic [CNT_W-1:0] PRESC_MAX = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] LONG_LIM  = CNT_W'(LONG_TICKS);
  localparam logic [CNT_W-1:0] GAP_LIM   = CNT_W'(GAP_TICKS);
`ifdef BUTTON_DECODER_REPEAT_EN
  localparam logic [1:0]       C_REPEAT  = 2'b00;
  localparam logic [CNT_W-1:0] REP_LIM   = CNT_W'(LONG_TICKS / 2);
`endif

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic [CNT_W-1:0] presc_q, presc_d;
  logic [CNT_W-1:0] dur_q, dur_d;
  logic [2:0]       state_q, state_d;
  logic             valid_q, valid_d;
  logic [1:0]       code_q, code_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;

  logic             tick;
  logic             emit;
  logic [1:0]       emit_code;
  logic             dur_clr;

  always_comb begin
    sync1_d = btn;
    sync2_d = sync1_q;

    // Free-running timebase; never realigned to button activity.
    tick    = (presc_q == PRESC_MAX);
    presc_d = tick ? '0 : presc_q + 1'b1;

    state_d   = state_q;
    emit      = 1'b0;
    emit_code = C_SHORT;
    dur_clr   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (sync2_q) state_d = S_PRESSED;
      end
      S_PRESSED: begin
        if (!sync2_q) begin
          state_d = S_WAIT_GAP;
        end else if (dur_q >= LONG_LIM) begin
          emit      = 1'b1;
          emit_code = C_LONG;
          state_d   = S_HELD;
        end
      end
      S_HELD: begin
        if (!sync2_q) begin
          state_d = S_IDLE;
        end
`ifdef BUTTON_DECODER_REPEAT_EN
        else if (dur_q >= REP_LIM) begin
          emit      = 1'b1;
          emit_code = C_REPEAT;
          dur_clr   = 1'b1;
        end
`endif
      end
      S_WAIT_GAP: begin
        // A new press takes priority over gap expiry.
        if (sync2_q) begin
          state_d = S_SECOND;
        end else if (dur_q >= GAP_LIM) begin
          emit      = 1'b1;
          emit_code = C_SHORT;
          state_d   = S_IDLE;
        end
      end
      S_SECOND: begin
        if (!sync2_q) begin
          emit      = 1'b1;
          emit_code = C_DOUBLE;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if ((state_d != state_q) || dur_clr) begin
      dur_d = '0;
    end else if (tick && (dur_q != '1)) begin
      dur_d = dur_q + 1'b1;
    end else begin
      dur_d = dur_q;
    end

    // An accept in the same cycle frees the slot for the new event.
    valid_d = valid_q;
    code_d  = code_q;
    ovf_d   = ovf_q;
    if (emit) begin
      if (valid_q && !evt.evt_ready) begin
        ovf_d = 1'b1;
      end else begin
        valid_d = 1'b1;
        code_d  = emit_code;
      end
    end else if (valid_q && evt.evt_ready) begin
      valid_d = 1'b0;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      presc_q <= '0;
      dur_q   <= '0;
      state_q <= S_IDLE;
      valid_q <= 1'b0;
      code_q  <= 2'b00;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      presc_q <= presc_d;
      dur_q   <= dur_d;
      state_q <= state_d;
      valid_q <= valid_d;
      code_q  <= code_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
    end
  end

  assign evt.evt_valid = valid_q;
  assign evt.evt_code  = code_q;
  assign overflow      = ovf_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_button_event_decoder.sv
// Bench for button_event_decoder: table vectors, directed corner cases and
// random traffic checked each cycle against a timestamp-based reference model.
module tb_button_event_decoder;

  localparam int TD = 4;
  localparam int TL = 10;
  localparam int TG = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       btn;
  logic       ready;
  logic       overflow;
  logic       busy;
  logic       evt_valid;
  logic [1:0] evt_code;

  button_event_decoder_if bus ();
  assign bus.evt_ready = ready;
  assign evt_valid     = bus.evt_valid;
  assign evt_code      = bus.evt_code;

  button_event_decoder #(
    .TICK_DIV  (TD),
    .LONG_TICKS(TL),
    .GAP_TICKS (TG),
    .CNT_W     (16)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .btn     (btn),
    .evt     (bus),
    .overflow(overflow),
    .busy    (busy)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: phase plus entry timestamp; duration is derived from
  // the cycle count since reset (a tick ends every TD-th cycle).
  typedef enum int {P_IDLE, P_PRESS, P_HELD, P_GAP, P_SECOND} phase_t;
  phase_t     m_ph = P_IDLE;
  phase_t     m_nx;
  int         m_k = 0;
  int         m_e = 0;
  bit         m_s1 = 0;
  bit         m_s2 = 0;
  bit         m_v = 0;
  bit         m_ovf = 0;
  logic [1:0] m_c = 2'b00;
  bit         m_emit;
  bit         m_rep;
  logic [1:0] m_ec;
  int         m_d;

  function automatic int m_dur();
    int d;
    d = m_k / TD - m_e / TD;
    if (d > 65535) d = 65535;
    return d;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_ph = P_IDLE; m_k = 0; m_e = 0;
      m_s1 = 0; m_s2 = 0;
      m_v = 0; m_c = 2'b00; m_ovf = 0;
    end else begin
      m_d = m_dur();
      m_nx = m_ph; m_emit = 0; m_rep = 0; m_ec = 2'b01;
      case (m_ph)
        P_IDLE:   if (m_s2) m_nx = P_PRESS;
        P_PRESS:  if (!m_s2) m_nx = P_GAP;
                  else if (m_d >= TL) begin m_emit = 1; m_ec = 2'b10; m_nx = P_HELD; end
        P_HELD:   if (!m_s2) m_nx = P_IDLE;
`ifdef BUTTON_DECODER_REPEAT_EN
                  else if (m_d >= TL / 2) begin m_emit = 1; m_ec = 2'b00; m_rep = 1; end
`endif
        P_GAP:    if (m_s2) m_nx = P_SECOND;
                  else if (m_d >= TG) begin m_emit = 1; m_ec = 2'b01; m_nx = P_IDLE; end
        P_SECOND: if (!m_s2) begin m_emit = 1; m_ec = 2'b11; m_nx = P_IDLE; end
        default:  m_nx = P_IDLE;
      endcase
      if (m_nx != m_ph || m_rep) m_e = m_k + 1;
      if (m_emit) begin
        if (m_v && !ready) m_ovf = 1;
        else begin m_v = 1; m_c = m_ec; end
      end else if (m_v && ready) begin
        m_v = 0;
      end
      m_ph = m_nx;
      m_k++;
      m_s2 = m_s1;
      m_s1 = btn;
    end
  end

  always @(negedge clk) begin
    n_cmp++;
    if (evt_valid !== m_v || overflow !== m_ovf ||
        busy !== (m_ph != P_IDLE) || (m_v && evt_code !== m_c)) begin
      n_err++;
      $display("FAIL model @%0t: got v=%b c=%b o=%b b=%b, want v=%b c=%b o=%b b=%b",
               $time, evt_valid, evt_code, overflow, busy,
               m_v, m_c, m_ovf, (m_ph != P_IDLE));
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", nm, got, exp);
    end
  endtask

  task automatic chk_rng(input string nm, input int got, input int lo, input int hi);
    n_cmp++;
    if (got < lo || got > hi) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d..%0d", nm, got, lo, hi);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_valid(input string nm, input int lim);
    int i;
    i = 0;
    while (!evt_valid && i < lim) begin
      @(negedge clk);
      i++;
    end
    chk(nm, evt_valid, 1);
  endtask

  typedef struct {
    int         hi1;
    int         lo;
    int         hi2;
    logic [1:0] code;
    int         n;
    int         lat_lo;
    int         lat_hi;
  } vec_t;

  vec_t tbl[6];

  task automatic run_vec(input vec_t v, input int idx);
    int total, nev, first;
    bit code_ok;
    total = v.hi1 + v.lo + v.hi2 + 80;
    nev = 0; first = -1; code_ok = 1;
    for (int t = 0; t < total; t++) begin
      @(negedge clk);
      if (evt_valid) begin
        nev++;
        if (first < 0) first = t;
        if (evt_code !== v.code) code_ok = 0;
      end
      btn = (t < v.hi1) ||
            (t >= v.hi1 + v.lo && t < v.hi1 + v.lo + v.hi2);
    end
    chk($sformatf("vec%0d_count", idx), nev, v.n);
    chk($sformatf("vec%0d_code", idx), code_ok, 1);
    chk_rng($sformatf("vec%0d_latency", idx), first, v.lat_lo, v.lat_hi);
    chk($sformatf("vec%0d_idle", idx), busy, 0);
  endtask

  bit found;
  int len, rmode;

  initial begin
    tbl[0] = '{20, 0,  0,  2'b01, 1, 41, 44};
    tbl[1] = '{60, 0,  0,  2'b10, 1, 41, 44};
    tbl[2] = '{12, 8,  12, 2'b11, 1, 35, 35};
    tbl[3] = '{30, 0,  0,  2'b01, 1, 51, 54};
    tbl[4] = '{8,  30, 8,  2'b01, 2, 29, 32};
    tbl[5] = '{4,  4,  4,  2'b11, 1, 15, 15};

    reset = 1'b1; btn = 1'b0; ready = 1'b1;
    idle(3);
    reset = 1'b0;
    idle(5);

    // Reset with the button held, then sync + state latency.
    btn = 1'b1; reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_valid", evt_valid, 0);
      chk("rst_code", evt_code, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_busy", busy, 0);
    end
    reset = 1'b0;
    @(negedge clk); chk("rst_busy_c1", busy, 0);
    @(negedge clk); chk("rst_busy_c2", busy, 0);
    @(negedge clk); chk("rst_busy_c3", busy, 1);
    btn = 1'b0;
    idle(80);

    for (int i = 0; i < 6; i++) run_vec(tbl[i], i);

    // Backpressure: pending SHORT, later LONG is dropped.
    ready = 1'b0;
    btn = 1'b1; idle(20); btn = 1'b0;
    wait_valid("bp_short_valid", 100);
    chk("bp_short_code", evt_code, 1);
    btn = 1'b1; idle(60);
    chk("bp_hold_valid", evt_valid, 1);
    chk("bp_hold_code", evt_code, 1);
    chk("bp_ovf", overflow, 1);
    btn = 1'b0; idle(10);
    ready = 1'b1;
    @(negedge clk);
    chk("bp_accept_valid", evt_valid, 0);
    chk("bp_ovf_sticky", overflow, 1);
    idle(40);

    // Accept of a pending SHORT in the exact LONG emission cycle.
    reset = 1'b1; ready = 1'b0; idle(2);
    reset = 1'b0; idle(3);
    btn = 1'b1; idle(20); btn = 1'b0;
    wait_valid("sc_short_valid", 100);
    chk("sc_short_code", evt_code, 1);
    btn = 1'b1;
    found = 0;
    for (int i = 0; i < 120 && !found; i++) begin
      @(negedge clk);
      if (m_ph == P_PRESS && m_s2 && m_dur() >= TL) begin
        ready = 1'b1;
        found = 1;
      end
    end
    chk("sc_emit_seen", found, 1);
    @(negedge clk);
    chk("sc_valid", evt_valid, 1);
    chk("sc_code", evt_code, 2);
    chk("sc_ovf", overflow, 0);
    btn = 1'b0; idle(10);
    chk("sc_drained", evt_valid, 0);
    idle(30);

    // Random traffic; the model checks every cycle.
    for (int s = 0; s < 60; s++) begin
      len = $urandom_range(2, 70);
      rmode = $urandom_range(0, 3);
      if ($urandom_range(0, 19) == 0) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
      end
      btn = ~btn;
      for (int i = 0; i < len; i++) begin
        ready = (rmode == 0) ? 1'b0 : ($urandom_range(0, 3) != 0);
        @(negedge clk);
      end
    end
    btn = 1'b0; ready = 1'b1;
    idle(100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

endmodule
